// File: rtl/cam_sched_pkg.sv
// cam_sched_pkg: shared state type and group helpers for camera_group_scheduler
package cam_sched_pkg;

    localparam int MAX_CAMS = 64;

    typedef enum logic [1:0] {IDLE, SCAN, MANUAL, ALARM} sched_state_t;

    function automatic int n_groups(input int n_cams, input int gsize);
        return (n_cams + gsize - 1) / gsize;
    endfunction

    function automatic logic [MAX_CAMS-1:0] grp_mask(input int n_cams, input int gsize, input int g);
        logic [MAX_CAMS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_CAMS; i++)
            m[i] = (i >= g * gsize) && (i < (g + 1) * gsize) && (i < n_cams);
        return m;
    endfunction

endpackage

// File: rtl/cam_alarm_encoder.sv
// cam_alarm_encoder: alarm vector -> {valid, group of lowest alarmed camera}
// alarm in N_CAMS; valid out 1 (any alarm); grp out GRP_W
module cam_alarm_encoder #(
    parameter int N_CAMS     = 9,
    parameter int GROUP_SIZE = 3,
    parameter int GRP_W      = 2
) (
    input  logic [N_CAMS-1:0] alarm,
    output logic              valid,
    output logic [GRP_W-1:0]  grp
);

    always_comb begin
        valid = |alarm;
        grp   = '0;
        for (int i = N_CAMS - 1; i >= 0; i--)
            if (alarm[i]) grp = GRP_W'(i / GROUP_SIZE);
    end

endmodule

// File: rtl/camera_group_scheduler.sv
// camera_group_scheduler: rotates camera groups with dwell, manual select and alarm override
// in: clk, reset, enable, dwell, manual_mode, manual_grp, alarm
// out: cam_en (group mask), group, alarm_active, group_wrap (all registered)
module camera_group_scheduler
    import cam_sched_pkg::*;
#(
    parameter  int N_CAMS     = 9,
    parameter  int GROUP_SIZE = 3,
    parameter  int DWELL_W    = 4,
    localparam int N_GROUPS   = n_groups(N_CAMS, GROUP_SIZE),
    localparam int GRP_W      = N_GROUPS > 1 ? $clog2(N_GROUPS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               manual_mode,
    input  logic [GRP_W-1:0]   manual_grp,
    input  logic [N_CAMS-1:0]  alarm,
    output logic [N_CAMS-1:0]  cam_en,
    output logic [GRP_W-1:0]   group,
    output logic               alarm_active,
    output logic               group_wrap
);

    localparam logic [GRP_W-1:0] LAST = GRP_W'(N_GROUPS - 1);

    sched_state_t       state, nxt_state;
    logic [DWELL_W-1:0] dwell_cnt, nxt_cnt;
    logic [GRP_W-1:0]   saved_grp, nxt_saved, nxt_grp, base_grp, alarm_grp;
    logic               alarm_valid, nxt_wrap, running;

    cam_alarm_encoder #(
        .N_CAMS    (N_CAMS),
        .GROUP_SIZE(GROUP_SIZE),
        .GRP_W     (GRP_W)
    ) u_enc (
        .alarm(alarm),
        .valid(alarm_valid),
        .grp  (alarm_grp)
    );

    // From IDLE/ALARM the resume point is saved_grp; from SCAN/MANUAL it is the live group.
    // Comparing with >= lets a shrunk dwell advance immediately instead of wrapping the counter.
    always_comb begin
        running   = state == SCAN || state == MANUAL;
        base_grp  = running ? group : saved_grp;
        nxt_state = SCAN;
        nxt_grp   = base_grp;
        nxt_cnt   = '0;
        nxt_saved = saved_grp;
        nxt_wrap  = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_grp   = group;
            nxt_saved = state != IDLE ? group : saved_grp;
        end else if (alarm_valid) begin
            nxt_state = ALARM;
            nxt_grp   = alarm_grp;
            nxt_saved = running ? group : saved_grp;
        end else if (manual_mode) begin
            nxt_state = MANUAL;
            nxt_grp   = manual_grp <= LAST ? manual_grp : base_grp;
        end else if (state == SCAN) begin
            nxt_grp  = dwell_cnt >= dwell ? (group == LAST ? '0 : group + GRP_W'(1)) : group;
            nxt_wrap = dwell_cnt >= dwell && group == LAST;
            nxt_cnt  = dwell_cnt >= dwell ? '0 : dwell_cnt + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            group        <= '0;
            dwell_cnt    <= '0;
            saved_grp    <= '0;
            cam_en       <= '0;
            alarm_active <= 1'b0;
            group_wrap   <= 1'b0;
        end else begin
            state        <= nxt_state;
            group        <= nxt_grp;
            dwell_cnt    <= nxt_cnt;
            saved_grp    <= nxt_saved;
            cam_en       <= nxt_state == IDLE ? '0 : N_CAMS'(grp_mask(N_CAMS, GROUP_SIZE, int'(nxt_grp)));
            alarm_active <= nxt_state == ALARM;
            group_wrap   <= nxt_wrap;
        end
    end

endmodule

// File: tb/tb_camera_group_scheduler.sv
// tb_camera_group_scheduler: directed vector bench for camera_group_scheduler
module tb_camera_group_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, manual_mode;
    logic [3:0] dwell;
    logic [1:0] manual_grp;
    logic [8:0] alarm, cam_en;
    logic [1:0] group;
    logic       alarm_active, group_wrap;

    logic       reset7, enable7, mm7;
    logic [3:0] dwell7;
    logic [1:0] mg7, group7;
    logic [6:0] alarm7, cam_en7;
    logic       aa7, wrap7;

    int checks = 0;
    int failures = 0;

    camera_group_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .dwell(dwell),
        .manual_mode(manual_mode), .manual_grp(manual_grp), .alarm(alarm),
        .cam_en(cam_en), .group(group), .alarm_active(alarm_active), .group_wrap(group_wrap)
    );

    camera_group_scheduler #(.N_CAMS(7), .GROUP_SIZE(3), .DWELL_W(4)) dut7 (
        .clk(clk), .reset(reset7), .enable(enable7), .dwell(dwell7),
        .manual_mode(mm7), .manual_grp(mg7), .alarm(alarm7),
        .cam_en(cam_en7), .group(group7), .alarm_active(aa7), .group_wrap(wrap7)
    );

    typedef struct {
        logic       r, en;
        logic [3:0] dw;
        logic       mm;
        logic [1:0] mg;
        logic [8:0] al;
        logic [8:0] cam;
        logic [1:0] grp;
        logic       aa, wr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, en, input logic [3:0] dw, input logic mm, input logic [1:0] mg,
                       input logic [8:0] al, cam, input logic [1:0] grp, input logic aa, wr);
        vq.push_back('{r, en, dw, mm, mg, al, cam, grp, aa, wr});
    endtask

    logic [6:0] exp7_cam[8] = '{7'h00, 7'h07, 7'h38, 7'h40, 7'h07, 7'h38, 7'h40, 7'h38};
    logic [1:0] exp7_grp[8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
    logic       exp7_wr[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic       exp7_aa[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [6:0] in7_al[8]   = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};

    initial begin
        //  r en dw mm mg al      cam     grp aa wr
        add(1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h007, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h007, 0, 0, 1);
        add(0, 1, 0, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h007, 0, 0, 1);
        add(0, 1, 2, 0, 0, 9'h000, 9'h007, 0, 0, 0);
        add(0, 1, 2, 0, 0, 9'h020, 9'h038, 1, 1, 0);
        add(0, 1, 2, 0, 0, 9'h020, 9'h038, 1, 1, 0);
        add(0, 1, 2, 0, 0, 9'h100, 9'h1C0, 2, 1, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h007, 0, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h007, 0, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h007, 0, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 1, 2, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 2, 1, 3, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 2, 1, 3, 9'h001, 9'h007, 0, 1, 0);
        add(0, 1, 2, 1, 1, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 0, 2, 0, 0, 9'h000, 9'h000, 2, 0, 0);
        add(0, 0, 2, 0, 0, 9'h000, 9'h000, 2, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 2, 0, 0, 9'h000, 9'h1C0, 2, 0, 0);
        add(0, 1, 2, 0, 0, 9'h040, 9'h1C0, 2, 1, 0);
        add(0, 1, 2, 0, 0, 9'h001, 9'h007, 0, 1, 0);
        add(1, 1, 2, 0, 0, 9'h001, 9'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h007, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h038, 1, 0, 0);
        add(0, 0, 0, 0, 0, 9'h1FF, 9'h000, 1, 0, 0);
        add(0, 1, 0, 0, 0, 9'h000, 9'h038, 1, 0, 0);

        reset7 = 1'b1; enable7 = 1'b0; dwell7 = '0; mm7 = 1'b0; mg7 = '0; alarm7 = '0;
        reset = 1'b1; enable = 1'b0; dwell = '0; manual_mode = 1'b0; manual_grp = '0; alarm = '0;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            reset = vq[i].r; enable = vq[i].en; dwell = vq[i].dw;
            manual_mode = vq[i].mm; manual_grp = vq[i].mg; alarm = vq[i].al;
            @(posedge clk); #1;
            chk("cam_en", i, 32'(cam_en), 32'(vq[i].cam));
            chk("group", i, 32'(group), 32'(vq[i].grp));
            chk("alarm_active", i, 32'(alarm_active), 32'(vq[i].aa));
            chk("group_wrap", i, 32'(group_wrap), 32'(vq[i].wr));
        end

        // partial last group: 7 cameras, groups 07/38/40
        for (int i = 0; i < 8; i++) begin
            reset7 = i == 0; enable7 = i != 0; alarm7 = in7_al[i];
            @(posedge clk); #1;
            chk("cam_en7", i, 32'(cam_en7), 32'(exp7_cam[i]));
            chk("group7", i, 32'(group7), 32'(exp7_grp[i]));
            chk("group_wrap7", i, 32'(wrap7), 32'(exp7_wr[i]));
            chk("alarm_active7", i, 32'(aa7), 32'(exp7_aa[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
